shift4_load_ctrl: RTL and testbench
===================================

// Module: shift4_load_ctrl
//
// PURPOSE
// Sequencer for the serial-in/parallel-out shift register (D-FF chain with shared set/reset,
// shifting on the falling clk edge). Accepts a parallel word over a valid/ready handshake,
// clears the register, shifts the word in serially MSB-first for WIDTH cycles, then pulses done
// with the register output equal to the accepted word. Sits between the word source and the register.
//
// PARAMETERS
// WIDTH      4   shift register length in bits; legal range 2..16
// DO_CLEAR   1   1: insert one CLEAR cycle before shifting; 0: go directly to SHIFT
//
// PORTS
// clk        in   1      system clock; controller state updates on rising edge
// r          in   1      asynchronous reset, active-high
// in_data    in   WIDTH  parallel word to load
// in_valid   in   1      in_data valid
// in_ready   out  1      controller can accept a word (high only in IDLE)
// sr_d       out  1      serial data to register D input
// sr_shift   out  1      shift enable; register shifts on falling clk edge of the same cycle
// sr_clr     out  1      synchronous clear request to register reset input
// sr_q       in   WIDTH  register parallel output (feedback)
// busy       out  1      high in CLEAR/SHIFT/DONE
// done       out  1      one-cycle pulse: sr_q holds the loaded word
//
// BEHAVIOUR
// - States: IDLE, CLEAR, SHIFT, DONE; all outputs registered (except in_ready = state==IDLE).
// - Reset (r high, async): state=IDLE, word=0, cnt=0, sr_d=0, sr_shift=0, done=0, busy=0,
//   sr_clr=1. in_ready=0 while r high. First rising edge after release: sr_clr=0, in_ready=1.
// - IDLE: in_valid&&in_ready at edge -> latch in_data to word, cnt=0; next CLEAR (DO_CLEAR=1) or SHIFT.
// - CLEAR: exactly 1 cycle, sr_clr=1, sr_shift=0 -> SHIFT.
// - SHIFT: WIDTH cycles; sr_shift=1, sr_d=word[WIDTH-1-cnt]; cnt increments each cycle;
//   cnt==WIDTH-1 -> DONE. cnt width = $clog2(WIDTH)+1; never wraps.
// - DONE: exactly 1 cycle, done=1, sr_shift=0; sr_q==word here -> IDLE.
// - Latency: accept edge at cycle 0 -> done high in cycle WIDTH+1+DO_CLEAR.
// - Throughput: in_ready low from accept until return to IDLE; in_valid ignored outside IDLE.
// - in_data only sampled at accept edge; later changes have no effect on the load in flight.
// - in_valid held high continuously: back-to-back loads, one IDLE cycle between them.
// - Reset mid-operation: load aborted, no done pulse, sr_clr=1 clears register; no partial state kept.
// - sr_d/sr_shift change only on rising edge -> stable half a cycle before falling-edge capture.
//
// CONFIGURATION
// - Macro SHIFT4_VERIFY_EN:
//   defined: adds output err (1 bit, reset 0). In DONE, err <= (sr_q != word); err holds
//     until the next accept, where it clears to 0. done pulses regardless of err.
//   undefined: no err port, no comparator; sr_q unused (kept in port list).
//
// TESTING
// - Reset then idle: r=1 two cycles -> sr_clr=1, in_ready=0, done=0; release -> in_ready=1, sr_clr=0.
// - Single load WIDTH=4, in_data=4'b1011 -> sr_d sequence 1,0,1,1 with sr_shift=1; done at cycle 6; sr_q=4'b1011.
// - DO_CLEAR=0, in_data=4'b0110 -> no sr_clr pulse; done at cycle 5; sr_q=4'b0110.
// - in_valid held high, words 4'hA then 4'h5 -> two done pulses 7 cycles apart; in_data changes mid-load ignored.
// - Reset asserted in cycle 3 of SHIFT -> immediate IDLE, sr_shift=0, no done; next load 4'hF completes correctly.
// - SHIFT4_VERIFY_EN, bench forces sr_q=4'h0 for word 4'h9 -> err=1 in cycle after DONE; next accept clears err.

Source files
------------

// File: rtl/shift4_load_ctrl_if.sv
// Word-source and shift-register bus of the shift4_load_ctrl sequencer.
// Optional err signal is present when SHIFT4_VERIFY_EN is defined.
interface shift4_load_ctrl_if #(parameter int WIDTH = 4);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             sr_d;
    logic             sr_shift;
    logic             sr_clr;
    logic [WIDTH-1:0] sr_q;
    logic             busy;
    logic             done;
`ifdef SHIFT4_VERIFY_EN
    logic             err;

    modport master (output in_data, in_valid, sr_q,
                    input  in_ready, sr_d, sr_shift, sr_clr, busy, done, err);
    modport slave  (input  in_data, in_valid, sr_q,
                    output in_ready, sr_d, sr_shift, sr_clr, busy, done, err);
`else
    modport master (output in_data, in_valid, sr_q,
                    input  in_ready, sr_d, sr_shift, sr_clr, busy, done);
    modport slave  (input  in_data, in_valid, sr_q,
                    output in_ready, sr_d, sr_shift, sr_clr, busy, done);
`endif
endinterface

// File: rtl/shift4_load_ctrl.sv
// Serial loader for a falling-edge SIPO register: accept word, optional clear, shift MSB-first, pulse done.
// Define SHIFT4_VERIFY_EN to add the err readback comparator.
module shift4_load_ctrl #(
    parameter int WIDTH    = 4,
    parameter int DO_CLEAR = 1
) (
    input  logic                 clk,
    input  logic                 r,
    shift4_load_ctrl_if.slave    bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int IW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

    state_t            state;
    logic [WIDTH-1:0]  word;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     nxt_idx;
    logic              sr_d_q, sr_shift_q, sr_clr_q, busy_q, done_q;

    // bit to present on the next SHIFT cycle (only used while cnt < LAST)
    assign nxt_idx = CW'(WIDTH - 2) - cnt;

    assign bus.in_ready = (state == IDLE) && !r;
    assign bus.sr_d     = sr_d_q;
    assign bus.sr_shift = sr_shift_q;
    assign bus.sr_clr   = sr_clr_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

`ifdef SHIFT4_VERIFY_EN
    logic err_q;
    assign bus.err = err_q;
`else
    logic unused_sr_q;
    assign unused_sr_q = ^bus.sr_q;
`endif

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state      <= IDLE;
            word       <= '0;
            cnt        <= '0;
            sr_d_q     <= 1'b0;
            sr_shift_q <= 1'b0;
            sr_clr_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SHIFT4_VERIFY_EN
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    sr_clr_q   <= 1'b0;
                    sr_shift_q <= 1'b0;
                    sr_d_q     <= 1'b0;
                    done_q     <= 1'b0;
                    if (bus.in_valid) begin
                        word   <= bus.in_data;
                        cnt    <= '0;
                        busy_q <= 1'b1;
`ifdef SHIFT4_VERIFY_EN
                        err_q  <= 1'b0;
`endif
                        if (DO_CLEAR != 0) begin
                            state    <= CLEAR;
                            sr_clr_q <= 1'b1;
                        end else begin
                            state      <= SHIFT;
                            sr_shift_q <= 1'b1;
                            sr_d_q     <= bus.in_data[WIDTH-1];
                        end
                    end
                end
                CLEAR: begin
                    state      <= SHIFT;
                    sr_clr_q   <= 1'b0;
                    sr_shift_q <= 1'b1;
                    sr_d_q     <= word[WIDTH-1];
                end
                SHIFT: begin
                    if (cnt == LAST) begin
                        state      <= DONE;
                        sr_shift_q <= 1'b0;
                        sr_d_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end else begin
                        cnt    <= cnt + 1'b1;
                        sr_d_q <= word[nxt_idx[IW-1:0]];
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
`ifdef SHIFT4_VERIFY_EN
                    err_q  <= (bus.sr_q != word);
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift4_load_ctrl.sv
// Scoreboard bench for shift4_load_ctrl: two instances (with/without CLEAR) feeding behavioural SIPO registers.
module tb_shift4_load_ctrl;
    localparam int W = 4;

    typedef struct {
        logic [W-1:0] word;
        int           when;
    } exp_t;

    logic clk = 1'b0;
    logic r   = 1'b1;
    always #5 clk = ~clk;

    shift4_load_ctrl_if #(.WIDTH(W)) a();
    shift4_load_ctrl_if #(.WIDTH(W)) b();

    shift4_load_ctrl #(.WIDTH(W), .DO_CLEAR(1)) u0 (.clk(clk), .r(r), .bus(a.slave));
    shift4_load_ctrl #(.WIDTH(W), .DO_CLEAR(0)) u1 (.clk(clk), .r(r), .bus(b.slave));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t q0s[$];
    exp_t q1s[$];
    exp_t e0, e1;
    logic [W-1:0] reg0 = '0, reg1 = '0, col0 = '0, col1 = '0;
    logic force0 = 1'b0;
    logic clr1 = 1'b0;
    int d0_last = 0, d0_prev = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // shift register models: shared clear, shift on falling edge
    always @(negedge clk) begin
        if (a.sr_clr) reg0 <= '0;
        else if (a.sr_shift) reg0 <= {reg0[W-2:0], a.sr_d};
        if (b.sr_clr) reg1 <= '0;
        else if (b.sr_shift) reg1 <= {reg1[W-2:0], b.sr_d};
    end

    assign a.sr_q = force0 ? '0 : reg0;
    assign b.sr_q = reg1;

    always @(negedge clk) begin
        if (a.in_valid && a.in_ready) begin
            q0s.push_back('{a.in_data, cyc + W + 2});
            col0 <= '0;
        end
        if (a.sr_shift) col0 <= {col0[W-2:0], a.sr_d};
        if (a.done) begin
            if (q0s.size() == 0) chk("done0_unexp", q0s.size(), 1);
            else begin
                e0 = q0s.pop_front();
                chk("done0_cyc", cyc, e0.when);
                chk("sr_q0", reg0, e0.word);
                chk("sr_d0_seq", col0, e0.word);
                chk("busy0_done", a.busy, 1);
            end
            d0_prev <= d0_last;
            d0_last <= cyc;
        end
    end

    always @(negedge clk) begin
        if (b.in_valid && b.in_ready) begin
            q1s.push_back('{b.in_data, cyc + W + 1});
            col1 <= '0;
            clr1 <= 1'b0;
        end else if (b.busy && b.sr_clr) clr1 <= 1'b1;
        if (b.sr_shift) col1 <= {col1[W-2:0], b.sr_d};
        if (b.done) begin
            if (q1s.size() == 0) chk("done1_unexp", q1s.size(), 1);
            else begin
                e1 = q1s.pop_front();
                chk("done1_cyc", cyc, e1.when);
                chk("sr_q1", reg1, e1.word);
                chk("sr_d1_seq", col1, e1.word);
                chk("clr1_seen", clr1, 0);
            end
        end
    end

    task automatic send0(input logic [W-1:0] w);
        a.in_data  = w;
        a.in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (a.in_ready) break;
        end
        chk("acc0", a.in_ready, 1);
        @(posedge clk);
        #1 a.in_valid = 1'b0;
    endtask

    task automatic send1(input logic [W-1:0] w);
        b.in_data  = w;
        b.in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (b.in_ready) break;
        end
        chk("acc1", b.in_ready, 1);
        @(posedge clk);
        #1 b.in_valid = 1'b0;
    endtask

    task automatic wait0();
        for (int i = 0; i < 100 && q0s.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        chk("drain0", q0s.size(), 0);
    endtask

    task automatic wait1();
        for (int i = 0; i < 100 && q1s.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        chk("drain1", q1s.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        a.in_valid = 1'b0; a.in_data = '0;
        b.in_valid = 1'b0; b.in_data = '0;

        // reset held two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_clr", a.sr_clr, 1);
        chk("rst_ready", a.in_ready, 0);
        chk("rst_done", a.done, 0);
        chk("rst_busy", a.busy, 0);
        chk("rst_shift", a.sr_shift, 0);
        @(posedge clk);
        #1 r = 1'b0;
        @(posedge clk);
        #1;
        chk("rel_ready", a.in_ready, 1);
        chk("rel_clr", a.sr_clr, 0);
        chk("rel_ready1", b.in_ready, 1);

        // single load with clear
        send0(4'b1011);
        wait0();

        // single load without clear
        send1(4'b0110);
        wait1();

        // back-to-back with in_valid held; in_data churns mid-load
        a.in_data  = 4'hA;
        a.in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (a.in_ready) break;
        end
        @(posedge clk);
        #1 a.in_data = 4'h3;
        repeat (3) @(posedge clk);
        #1 a.in_data = 4'h5;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (a.in_ready) break;
        end
        @(posedge clk);
        #1 a.in_valid = 1'b0;
        wait0();
        chk("b2b_gap", d0_last - d0_prev, 7);

        // reset in third SHIFT cycle aborts the load
        send0(4'hC);
        repeat (3) @(posedge clk);
        #3 r = 1'b1;
        q0s.delete();
        #1;
        chk("abort_shift", a.sr_shift, 0);
        chk("abort_busy", a.busy, 0);
        chk("abort_ready", a.in_ready, 0);
        chk("abort_clr", a.sr_clr, 1);
        @(posedge clk);
        @(negedge clk);
        chk("abort_reg", reg0, 0);
        @(posedge clk);
        #1 r = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_nodone", q0s.size(), 0);
        send0(4'hF);
        wait0();

`ifdef SHIFT4_VERIFY_EN
        force0 = 1'b1;
        send0(4'h9);
        wait0();
        chk("err_set", a.err, 1);
        force0 = 1'b0;
        send0(4'h2);
        chk("err_clr_acc", a.err, 0);
        wait0();
        chk("err_ok", a.err, 0);
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
